// File: rtl/i2c_codec_responder_if.sv
// I2C line bundle for the codec-control responder.
//   scl_in   : I2C clock line as seen on the bus (sampled, never used as a clock)
//   sda_in   : I2C data line as seen on the bus (wired-AND already resolved)
//   sda_oe   : 1 = responder pulls SDA low (ACK), 0 = released
//   bus_busy : high from START detect to STOP detect
// master modport: the bus side (initiator / bench); slave modport: the responder.
interface i2c_codec_responder_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;
  logic bus_busy;

  modport master (
    output scl_in,
    output sda_in,
    input  sda_oe,
    input  bus_busy
  );

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_oe,
    output bus_busy
  );
endinterface

// File: rtl/i2c_codec_responder.sv
// I2C target for the write-only 16-bit codec control protocol:
//   START, address byte, {reg[6:0], data[8]}, data[7:0], STOP.
// Holds a 9-bit register file and pulses wr_strobe once per accepted write.
// SCL/SDA are oversampled through 2-FF synchronizers in the clock domain.
//
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus            : I2C lines (scl_in, sda_in in; sda_oe, bus_busy out)
//   wr_strobe      : one-cycle pulse per accepted register write
//   wr_addr/wr_data: register address / data of the last accepted write
//   rd_addr/rd_data: combinational register-file read, 0 beyond NUM_REGS
//
// Build option: define I2C_GLITCH_FILTER_EN to insert a FILTER_LEN-clock
// stability filter after the synchronizers on both lines.
module i2c_codec_responder #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned NUM_REGS   = 10,
  parameter logic [6:0]  RESET_REG  = 7'h0F,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  i2c_codec_responder_if.slave        bus,
  output logic                        wr_strobe,
  output logic [6:0]                  wr_addr,
  output logic [8:0]                  wr_data,
  input  logic [3:0]                  rd_addr,
  output logic [8:0]                  rd_data
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StByte1, StAck1, StByte2, StAck2, StIgnore
  } state_e;

  // Line vectors: bit 1 = SCL, bit 0 = SDA. Idle bus is high, so reset to 1
  // to avoid phantom edges when reset is released.
  logic [1:0] sync1_q, sync2_q, line_filt, line_prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {bus.scl_in, bus.sda_in};
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] filt_q;
  logic [7:0] filt_cnt_q [2];

  // Filtered value follows the raw value only after it has differed for
  // FILTER_LEN consecutive clocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_q        <= 2'b11;
      filt_cnt_q[0] <= '0;
      filt_cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (filt_cnt_q[i] >= 8'(FILTER_LEN - 1)) begin
            filt_q[i]     <= sync2_q[i];
            filt_cnt_q[i] <= '0;
          end else begin
            filt_cnt_q[i] <= filt_cnt_q[i] + 8'd1;
          end
        end else begin
          filt_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign line_filt = filt_q;
`else
  assign line_filt = sync2_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) line_prev_q <= 2'b11;
    else          line_prev_q <= line_filt;
  end

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
  assign scl       = line_filt[1];
  assign sda       = line_filt[0];
  assign scl_rise  = scl & ~line_prev_q[1];
  assign scl_fall  = ~scl & line_prev_q[1];
  // SCL must be high in both samples so an SCL edge never fakes START/STOP.
  assign start_det = scl & line_prev_q[1] & line_prev_q[0] & ~sda;
  assign stop_det  = scl & line_prev_q[1] & ~line_prev_q[0] & sda;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte1_q, byte1_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic       reg_we, reg_clr;
  logic [8:0] regs_q [NUM_REGS];

  // Register address/data of the write in flight, valid once byte 2 is shifted.
  logic [6:0] cur_reg;
  logic [8:0] cur_data;
  assign cur_reg  = byte1_q[7:1];
  assign cur_data = {byte1_q[0], shift_q};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte1_d     = byte1_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    reg_clr     = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      shift_d   = '0;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        StAddr, StByte1, StByte2: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == StAddr) begin
              if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                state_d  = StAddrAck;
                sda_oe_d = 1'b1;
              end else begin
                state_d  = StIgnore;
              end
            end else if (state_q == StByte1) begin
              byte1_d  = shift_q;
              sda_oe_d = 1'b1;
              state_d  = StAck1;
            end else begin
              if (32'(cur_reg) < NUM_REGS || cur_reg == RESET_REG) begin
                sda_oe_d    = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = cur_reg;
                wr_data_d   = cur_data;
                reg_we      = 1'b1;
                reg_clr     = (cur_reg == RESET_REG);
              end
              state_d = StAck2;
            end
          end
        end
        StAddrAck, StAck1, StAck2: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            unique case (state_q)
              StAddrAck: state_d = StByte1;
              StAck1:    state_d = StByte2;
              default:   state_d = StIgnore;
            endcase
          end
        end
        StIdle, StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte1_q     <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte1_q     <= byte1_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Clear wins over a write, so a RESET_REG inside the implemented range still clears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (reg_clr) begin
          regs_q[i] <= '0;
        end else if (reg_we && 32'(cur_reg) == i) begin
          regs_q[i] <= cur_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (32'(rd_addr) == i) rd_data = regs_q[i];
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.bus_busy = busy_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;

endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
- I2C target (responder) for the write-only 16-bit codec control protocol the codec-config initiator emits: address byte, then {reg[6:0], data[8]}, then data[7:0].
- Used on-chip as a register-model endpoint for bench and loopback of the config path, and as a control-port target for the effects chain.
- Holds a 9-bit register file and reports every accepted write on a one-cycle strobe.
- Single clock domain; SCL and SDA are oversampled, not used as clocks.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address matched against the address byte.
- NUM_REGS, 10, number of implemented registers at addresses 0..NUM_REGS-1.
- RESET_REG, 7'h0F, register address whose write clears the whole register file.
- FILTER_LEN, 3, stable-sample count for the optional glitch filter.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  I2C clock line, sampled.
- sda_in  in  1  I2C data line, sampled.
- sda_oe  out  1  1 = drive SDA low (ACK); 0 = release.
- wr_strobe  out  1  one-cycle pulse per accepted register write.
- wr_addr  out  7  register address of the last accepted write.
- wr_data  out  9  data of the last accepted write.
- rd_addr  in  4  register-file read address, combinational read.
- rd_data  out  9  register contents at rd_addr; 0 if rd_addr >= NUM_REGS.
- bus_busy  out  1  high from START detect to STOP detect.

Behaviour:
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer.
  - Edges are detected on the synchronized signals.
  - SCL low and high phases must each be >= 4 clocks.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on the synchronized SCL rising edge, MSB first.
- Reset: state IDLE, sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, bus_busy=0, all registers 0.
- FSM states: IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
- IDLE: START -> ADDR and set bus_busy.
- ADDR: shift 8 bits, then at the SCL falling edge after bit 0:
  - upper 7 bits == DEV_ADDR and R/W=0 -> ADDR_ACK, sda_oe=1.
  - anything else -> IGNORE, sda_oe stays 0 (NACK).
- ADDR_ACK, ACK1: release sda_oe at the next SCL falling edge, then go to BYTE1 or BYTE2 respectively.
- BYTE1: latch the byte, then always ACK (-> ACK1).
- BYTE2: at the SCL falling edge after bit 0:
  - reg < NUM_REGS or reg == RESET_REG: sda_oe=1, wr_strobe pulses in the same cycle, wr_addr/wr_data update, register file updates (visible on rd_data the next cycle).
  - RESET_REG write: all registers cleared to 0; wr_data still reports the written value.
  - Otherwise: NACK, no strobe, no write.
  - Either way -> ACK2.
- ACK2: release sda_oe at the next SCL falling edge -> IGNORE.
- IGNORE: further bytes in the transaction are NACKed and have no effect. Only START or STOP leaves this state.
- START in any state, including repeated START mid-byte: discard partial shift data, sda_oe=0, -> ADDR.
- STOP in any state: sda_oe=0, bus_busy=0, -> IDLE; a partial write is discarded.
- Asserting reset_n mid-transaction forces the full reset state immediately.
- wr_strobe is never asserted for two consecutive cycles.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: after the synchronizers, each line's filtered value changes only after the raw synchronized value has differed for FILTER_LEN consecutive clocks. Pulses shorter than FILTER_LEN clocks are suppressed, and detection latency grows by FILTER_LEN clocks.
- Undefined: the synchronizer outputs feed edge detection directly.

Test Plan:
- Write 0x34, 0x08, 0x12 with STOP -> ACK on all three bytes; one wr_strobe with wr_addr=0x04, wr_data=0x012; rd_addr=4 gives 0x012.
- Write 0x34, 0x0D, 0xFF -> reg 6 = 0x1FF. Then write 0x34, 0x1E, 0x00 (reg 0x0F) -> one strobe; all rd_data read 0 afterwards.
- Address byte 0x36 (wrong address) and 0x35 (read) -> sda_oe never asserts, no strobe, bus_busy high until STOP.
- Write 0x34, 0x16, 0x55 (reg 0x0B, not implemented) -> ACK on first two bytes, NACK on third, no strobe; a trailing 4th byte is NACKed.
- Repeated START after 4 bits of byte 2, then a full write of reg 2 = 0x07F -> only reg 2 changes; exactly one strobe.
- With I2C_GLITCH_FILTER_EN: a 2-clock SDA low pulse while SCL is high -> no START detected; a 5-clock pulse -> START detected, bus_busy=1.
